// File: rtl/bcd_pkg.sv
// -----------------------------------------------------------------------------
// bcd_pkg
// Items shared by the BCD down timer and its per-decade digit cell:
//   DIGIT_W  - width of one BCD decade
//   BCD_MAX  - largest legal BCD digit
//   state_t  - control FSM encoding (IDLE / RUN / HALT)
//   bcd_clamp() - forces any non-BCD digit code (>9) to 9
// -----------------------------------------------------------------------------
package bcd_pkg;

  localparam int unsigned DIGIT_W = 4;
  localparam logic [DIGIT_W-1:0] BCD_MAX = 4'd9;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    HALT = 2'd2
  } state_t;

  function automatic logic [DIGIT_W-1:0] bcd_clamp(input logic [DIGIT_W-1:0] d);
    return (d > BCD_MAX) ? BCD_MAX : d;
  endfunction

endpackage

// File: rtl/bcd_digit.sv
// -----------------------------------------------------------------------------
// bcd_digit
// One BCD decade of the ripple-enabled counter chain.
// Ports:
//   clk       - clock, rising edge
//   clr       - asynchronous active-high clear (digit -> 0)
//   load      - synchronous load, highest priority after clr
//   load_val  - value taken on load (caller supplies a legal BCD code)
//   cin       - step request from the lower decade (carry up / borrow down)
//   hold      - freezes the digit even when cin is set
//   up        - direction: 1 = increment, 0 = decrement
//   q         - current digit
//   cout      - step request passed to the next decade: cin while this digit
//               sits at its wrap value (9 counting up, 0 counting down)
// -----------------------------------------------------------------------------
module bcd_digit
  import bcd_pkg::*;
(
  input  logic               clk,
  input  logic               clr,
  input  logic               load,
  input  logic [DIGIT_W-1:0] load_val,
  input  logic               cin,
  input  logic               hold,
  input  logic               up,
  output logic [DIGIT_W-1:0] q,
  output logic               cout
);

  logic               at_wrap;
  logic [DIGIT_W-1:0] q_next;

  assign at_wrap = up ? (q == BCD_MAX) : (q == '0);
  assign cout    = cin & at_wrap;

  // Wrapping explicitly at 9/0 keeps the digit inside the BCD code space.
  always_comb begin
    q_next = q;
    if (up) begin
      q_next = (q == BCD_MAX) ? '0 : q + 4'd1;
    end else begin
      q_next = (q == '0) ? BCD_MAX : q - 4'd1;
    end
  end

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      q <= '0;
    end else if (load) begin
      q <= load_val;
    end else if (cin && !hold) begin
      q <= q_next;
    end
  end

endmodule

// File: rtl/bcd_down_timer.sv
// -----------------------------------------------------------------------------
// bcd_down_timer
// Multi-decade BCD up/down timer with load, auto-reload and halt-at-terminal.
// Parameters:
//   DIGITS      - number of cascaded BCD decades (1..8)
// Ports:
//   clk         - clock, rising edge
//   clr         - asynchronous active-high reset
//   data        - BCD load value, digit 0 in [3:0]; digits >9 clamp to 9
//   loadn       - synchronous load, active-low; works in every state, any en
//   en          - count enable (only honoured in RUN)
//   up          - direction, 1 = up, 0 = down
//   auto_reload - at terminal: 1 = wrap (reload value / 0), 0 = halt
//   count       - registered BCD count
//   tc          - en AND count at terminal (all 9s up, all 0s down)
//   zero        - count == 0, regardless of en
//   done        - registered one-cycle pulse after each enabled terminal step
//   halted      - FSM is in HALT
//   state_dbg   - raw FSM state for observation
//
// Handshake: none; loadn/en are level inputs sampled on every rising edge with
// priority clr > load > en.
// -----------------------------------------------------------------------------
module bcd_down_timer
  import bcd_pkg::*;
#(
  parameter int unsigned DIGITS = 2
) (
  input  logic                      clk,
  input  logic                      clr,
  input  logic [DIGIT_W*DIGITS-1:0] data,
  input  logic                      loadn,
  input  logic                      en,
  input  logic                      up,
  input  logic                      auto_reload,
  output logic [DIGIT_W*DIGITS-1:0] count,
  output logic                      tc,
  output logic                      zero,
  output logic                      done,
  output logic                      halted,
  output state_t                    state_dbg
);

  localparam int unsigned W = DIGIT_W * DIGITS;

  state_t         state;
  logic [W-1:0]   reload_reg;
  logic [W-1:0]   data_clamped;
  logic [W-1:0]   digit_load_val;
  logic [DIGITS:0] chain;
  logic           load;
  logic           run_en;
  logic           term_step;
  logic           digit_load;
  logic           at_term;

  assign load   = ~loadn;
  assign run_en = (state == RUN) & en;

  // Terminal pattern depends on the live direction, so a change of up is
  // seen on the very next enabled step.
  always_comb begin
    at_term = 1'b1;
    for (int k = 0; k < DIGITS; k++) begin
      if (up) begin
        if (count[k*DIGIT_W +: DIGIT_W] != BCD_MAX) at_term = 1'b0;
      end else begin
        if (count[k*DIGIT_W +: DIGIT_W] != '0) at_term = 1'b0;
      end
    end
  end

  always_comb begin
    data_clamped = '0;
    for (int k = 0; k < DIGITS; k++) begin
      data_clamped[k*DIGIT_W +: DIGIT_W] = bcd_clamp(data[k*DIGIT_W +: DIGIT_W]);
    end
  end

  // The enable ripples through every decade; it only falls out of the top
  // when all decades sit at their wrap value, i.e. the terminal step.
  assign chain[0]  = run_en;
  assign term_step = chain[DIGITS];

  // An auto-reload is done with the digits' own load path.
  assign digit_load     = load | (term_step & auto_reload);
  assign digit_load_val = load ? data_clamped : (up ? '0 : reload_reg);

  for (genvar g = 0; g < DIGITS; g++) begin : g_digit
    bcd_digit u_digit (
      .clk      (clk),
      .clr      (clr),
      .load     (digit_load),
      .load_val (digit_load_val[g*DIGIT_W +: DIGIT_W]),
      .cin      (chain[g]),
      .hold     (term_step),
      .up       (up),
      .q        (count[g*DIGIT_W +: DIGIT_W]),
      .cout     (chain[g+1])
    );
  end

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      state      <= IDLE;
      reload_reg <= '0;
      done       <= 1'b0;
    end else begin
      // A load in the same cycle as a terminal step suppresses its done.
      done <= term_step & ~load;
      if (load) begin
        state      <= RUN;
        reload_reg <= data_clamped;
      end else if (term_step && !auto_reload) begin
        state <= HALT;
      end
    end
  end

  assign tc        = en & at_term;
  assign zero      = (count == '0);
  assign halted    = (state == HALT);
  assign state_dbg = state;

endmodule

// File: tb/tb_bcd_down_timer.sv
// -----------------------------------------------------------------------------
// tb_bcd_down_timer
// Directed bench for bcd_down_timer with DIGITS=2.
// -----------------------------------------------------------------------------
module tb_bcd_down_timer;
  import bcd_pkg::*;

  logic       clk;
  logic       clr;
  logic [7:0] data;
  logic       loadn;
  logic       en;
  logic       up;
  logic       auto_reload;
  logic [7:0] count;
  logic       tc;
  logic       zero;
  logic       done;
  logic       halted;
  state_t     state_dbg;

  int checks = 0;
  int errors = 0;
  logic [7:0] exp_q[$];

  bcd_down_timer #(.DIGITS(2)) dut (
    .clk         (clk),
    .clr         (clr),
    .data        (data),
    .loadn       (loadn),
    .en          (en),
    .up          (up),
    .auto_reload (auto_reload),
    .count       (count),
    .tc          (tc),
    .zero        (zero),
    .done        (done),
    .halted      (halted),
    .state_dbg   (state_dbg)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL timeout: bench did not finish");
    $fatal(1, "timeout");
  end

  // driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load_val(input logic [7:0] d);
    loadn = 1'b0;
    data  = d;
    tick();
    loadn = 1'b1;
  endtask

  task automatic test_reset();
    clr = 1'b1; loadn = 1'b1; en = 1'b1; up = 1'b0; auto_reload = 1'b0; data = 8'h00;
    #2;
    checks++; if (count !== 8'h00) begin errors++; $display("FAIL reset_count got %h want 00", count); end
    checks++; if (zero !== 1'b1) begin errors++; $display("FAIL reset_zero got %b want 1", zero); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done got %b want 0", done); end
    checks++; if (halted !== 1'b0) begin errors++; $display("FAIL reset_halted got %b want 0", halted); end
    checks++; if (state_dbg !== IDLE) begin errors++; $display("FAIL reset_state got %0d want IDLE", state_dbg); end
    checks++; if (tc !== 1'b1) begin errors++; $display("FAIL reset_tc_down got %b want 1", tc); end
    up = 1'b1;
    #1;
    checks++; if (tc !== 1'b0) begin errors++; $display("FAIL reset_tc_up got %b want 0", tc); end
    up = 1'b0;
    tick();
    clr = 1'b0;
  endtask

  task automatic test_idle_ignores_en();
    en = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++; if (count !== 8'h00 || done !== 1'b0 || state_dbg !== IDLE) begin
        errors++; $display("FAIL idle_hold cyc %0d count %h done %b state %0d want 00 0 IDLE", i, count, done, state_dbg);
      end
    end
  endtask

  task automatic test_down_halt();
    logic [7:0] e;
    en = 1'b1; up = 1'b0; auto_reload = 1'b0;
    load_val(8'h03);
    checks++; if (count !== 8'h03 || state_dbg !== RUN) begin
      errors++; $display("FAIL halt_load count %h state %0d want 03 RUN", count, state_dbg);
    end
    exp_q = '{8'h02, 8'h01, 8'h00};
    while (exp_q.size() > 0) begin
      tick();
      e = exp_q.pop_front();
      checks++; if (count !== e || done !== 1'b0) begin
        errors++; $display("FAIL halt_step count %h done %b want %h 0", count, done, e);
      end
    end
    checks++; if (tc !== 1'b1) begin errors++; $display("FAIL halt_tc got %b want 1", tc); end
    tick();
    checks++; if (done !== 1'b1 || halted !== 1'b1 || count !== 8'h00) begin
      errors++; $display("FAIL halt_term done %b halted %b count %h want 1 1 00", done, halted, count);
    end
    tick();
    checks++; if (done !== 1'b0 || halted !== 1'b1 || count !== 8'h00) begin
      errors++; $display("FAIL halt_hold done %b halted %b count %h want 0 1 00", done, halted, count);
    end
    en = 1'b0;
    load_val(8'h01);
    checks++; if (count !== 8'h01 || halted !== 1'b0 || state_dbg !== RUN) begin
      errors++; $display("FAIL halt_reload count %h halted %b state %0d want 01 0 RUN", count, halted, state_dbg);
    end
  endtask

  task automatic test_borrow();
    logic [7:0] e;
    en = 1'b1; up = 1'b0; auto_reload = 1'b0;
    load_val(8'h10);
    checks++; if (count !== 8'h10) begin errors++; $display("FAIL borrow_load got %h want 10", count); end
    tick();
    checks++; if (count !== 8'h09) begin errors++; $display("FAIL borrow_cross got %h want 09", count); end
    e = 8'h08;
    for (int i = 0; i < 7; i++) begin
      tick();
      checks++; if (count !== e || count[3:0] > 4'd9 || count[7:4] > 4'd9) begin
        errors++; $display("FAIL borrow_seq got %h want %h", count, e);
      end
      e = e - 8'h01;
    end
  endtask

  task automatic test_up_wrap();
    en = 1'b1; up = 1'b1; auto_reload = 1'b1;
    load_val(8'h98);
    checks++; if (count !== 8'h98 || tc !== 1'b0) begin
      errors++; $display("FAIL upwrap_load count %h tc %b want 98 0", count, tc);
    end
    tick();
    checks++; if (count !== 8'h99 || tc !== 1'b1 || done !== 1'b0) begin
      errors++; $display("FAIL upwrap_99 count %h tc %b done %b want 99 1 0", count, tc, done);
    end
    tick();
    checks++; if (count !== 8'h00 || done !== 1'b1 || state_dbg !== RUN) begin
      errors++; $display("FAIL upwrap_00 count %h done %b state %0d want 00 1 RUN", count, done, state_dbg);
    end
    tick();
    checks++; if (count !== 8'h01 || done !== 1'b0) begin
      errors++; $display("FAIL upwrap_01 count %h done %b want 01 0", count, done);
    end
  endtask

  task automatic test_clamp();
    en = 1'b0; up = 1'b0; auto_reload = 1'b0;
    load_val(8'h2A);
    checks++; if (count !== 8'h29 || state_dbg !== RUN) begin
      errors++; $display("FAIL clamp_2a count %h state %0d want 29 RUN", count, state_dbg);
    end
    tick();
    checks++; if (count !== 8'h29) begin errors++; $display("FAIL clamp_en0_hold got %h want 29", count); end
    load_val(8'hFB);
    checks++; if (count !== 8'h99) begin errors++; $display("FAIL clamp_fb got %h want 99", count); end
  endtask

  task automatic test_dir_change();
    en = 1'b1; up = 1'b1; auto_reload = 1'b0;
    load_val(8'h50);
    tick();
    checks++; if (count !== 8'h51) begin errors++; $display("FAIL dir_up got %h want 51", count); end
    up = 1'b0;
    tick();
    checks++; if (count !== 8'h50) begin errors++; $display("FAIL dir_down1 got %h want 50", count); end
    tick();
    checks++; if (count !== 8'h49) begin errors++; $display("FAIL dir_down2 got %h want 49", count); end
  endtask

  task automatic test_down_reload();
    en = 1'b1; up = 1'b0; auto_reload = 1'b1;
    load_val(8'h02);
    tick();
    checks++; if (count !== 8'h01) begin errors++; $display("FAIL reload_01 got %h want 01", count); end
    tick();
    checks++; if (count !== 8'h00 || done !== 1'b0) begin
      errors++; $display("FAIL reload_00 count %h done %b want 00 0", count, done);
    end
    tick();
    checks++; if (count !== 8'h02 || done !== 1'b1 || state_dbg !== RUN) begin
      errors++; $display("FAIL reload_wrap count %h done %b state %0d want 02 1 RUN", count, done, state_dbg);
    end
    tick();
    checks++; if (count !== 8'h01 || done !== 1'b0) begin
      errors++; $display("FAIL reload_after count %h done %b want 01 0", count, done);
    end
  endtask

  task automatic test_zero_reload();
    en = 1'b1; up = 1'b0; auto_reload = 1'b1;
    load_val(8'h00);
    checks++; if (count !== 8'h00 || done !== 1'b0 || zero !== 1'b1) begin
      errors++; $display("FAIL zr_load count %h done %b zero %b want 00 0 1", count, done, zero);
    end
    for (int i = 0; i < 2; i++) begin
      tick();
      checks++; if (count !== 8'h00 || done !== 1'b1) begin
        errors++; $display("FAIL zr_pulse cyc %0d count %h done %b want 00 1", i, count, done);
      end
    end
    en = 1'b0;
    #1;
    checks++; if (zero !== 1'b1 || tc !== 1'b0) begin
      errors++; $display("FAIL zr_en0 zero %b tc %b want 1 0", zero, tc);
    end
    tick();
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL zr_stop got %b want 0", done); end
  endtask

  task automatic test_clr_mid();
    en = 1'b1; up = 1'b0; auto_reload = 1'b0;
    load_val(8'h08);
    for (int i = 0; i < 3; i++) tick();
    checks++; if (count !== 8'h05) begin errors++; $display("FAIL clr_pre got %h want 05", count); end
    clr = 1'b1;
    #1;
    checks++; if (count !== 8'h00 || done !== 1'b0 || halted !== 1'b0 || state_dbg !== IDLE || zero !== 1'b1) begin
      errors++; $display("FAIL clr_async count %h done %b halted %b state %0d zero %b want 00 0 0 IDLE 1",
                         count, done, halted, state_dbg, zero);
    end
    tick();
    clr = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++; if (count !== 8'h00 || done !== 1'b0 || state_dbg !== IDLE) begin
        errors++; $display("FAIL clr_idle cyc %0d count %h done %b state %0d want 00 0 IDLE", i, count, done, state_dbg);
      end
    end
  endtask

  task automatic test_load_at_terminal();
    en = 1'b1; up = 1'b0; auto_reload = 1'b0;
    load_val(8'h01);
    tick();
    checks++; if (count !== 8'h00) begin errors++; $display("FAIL lat_pre got %h want 00", count); end
    loadn = 1'b0; data = 8'h45;
    tick();
    loadn = 1'b1;
    checks++; if (count !== 8'h45 || done !== 1'b0 || state_dbg !== RUN || halted !== 1'b0) begin
      errors++; $display("FAIL lat_load count %h done %b state %0d halted %b want 45 0 RUN 0",
                         count, done, state_dbg, halted);
    end
    tick();
    checks++; if (count !== 8'h44 || done !== 1'b0) begin
      errors++; $display("FAIL lat_next count %h done %b want 44 0", count, done);
    end
  endtask

  initial begin
    test_reset();
    test_idle_ignores_en();
    test_down_halt();
    test_borrow();
    test_up_wrap();
    test_clamp();
    test_dir_change();
    test_down_reload();
    test_zero_reload();
    test_clr_mid();
    test_load_at_terminal();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/bcd_down_timer.md
BCD_DOWN_TIMER -- requirements
Module: bcd_down_timer

Interface
REQ-001 SHALL have parameter DIGITS, default 2, meaning the number of cascaded BCD decades (legal range 1..8).
REQ-002 SHALL have port clk  input  1  meaning the single clock; all state changes on its rising edge.
REQ-003 SHALL have port clr  input  1  meaning the reset, which is asynchronous and active-high.
REQ-004 SHALL have port data  input  4*DIGITS  meaning the BCD load value, with digit 0 in bits [3:0].
REQ-005 SHALL have port loadn  input  1  meaning synchronous load, active-low.
REQ-006 SHALL have port en  input  1  meaning count enable, active-high.
REQ-007 SHALL have port up  input  1  meaning direction: 1 counts up, 0 counts down.
REQ-008 SHALL have port auto_reload  input  1  meaning wrap at terminal when 1, or halt at terminal when 0.
REQ-009 SHALL have port count  output  4*DIGITS  meaning the current BCD value (registered).
REQ-010 SHALL have port tc  output  1  meaning combinational terminal count: en AND count==terminal.
REQ-011 SHALL have port zero  output  1  meaning combinational count==0, independent of en.
REQ-012 SHALL have port done  output  1  meaning a registered one-cycle pulse on each terminal step.
REQ-013 SHALL have port halted  output  1  meaning high while the FSM is in HALT.

Function
REQ-014 SHALL define terminal as all digits 0 when up=0, and all digits 9 when up=1.
REQ-015 SHALL run FSM states IDLE, RUN and HALT.
REQ-016 SHALL make the transitions IDLE->RUN on load, RUN->HALT on an enabled terminal step with auto_reload=0, and HALT->RUN on load only.
REQ-017 SHALL apply the priority clr > load (loadn=0) > en; load SHALL act regardless of en and of state.
REQ-018 SHALL, on load, set count <= data and reload_reg <= data, with any digit >9 clamped to 9.
REQ-019 SHALL ignore en in IDLE and HALT; count holds.
REQ-020 SHALL, in RUN with en=1 and count!=terminal, step count by ±1 in BCD: per-digit wrap 9->0 with carry (up), or 0->9 with borrow (down); never step to a non-BCD code.
REQ-021 SHALL, in RUN with en=1 and count==terminal and auto_reload=1, set count <= reload_reg (down) or count <= 0 (up); the state stays RUN.
REQ-022 SHALL, in RUN with en=1 and count==terminal and auto_reload=0, hold count and enter HALT.
REQ-023 SHALL assert done for exactly one cycle following every enabled terminal step (REQ-021 or REQ-022); a load in the same cycle cancels that done.
REQ-024 SHALL let a change of up mid-run take effect on the next enabled step with no extra latency.
REQ-025 SHALL, when reload_reg==0 in down mode with auto_reload=1, produce done on every enabled cycle while count stays 0.

Reset
REQ-026 SHALL, on clr=1, asynchronously force count=0, reload_reg=0, state=IDLE, done=0 and halted=0; zero SHALL read 1 and tc SHALL read en AND (up=0).
REQ-027 SHALL, when clr is asserted mid-count, abort without a done pulse; after clr falls, the block SHALL remain in IDLE until a load.

Structure
REQ-028 SHALL place DIGIT_W=4, BCD_MAX=4'd9 and the FSM state enum (IDLE/RUN/HALT) in shared package bcd_pkg.
REQ-029 SHALL instantiate one sub-module, bcd_digit, DIGITS times; it SHALL be a single decade with inc/dec, carry/borrow in and out, and load.
REQ-030 SHALL keep the FSM and reload_reg in the top level; the digit chain SHALL be ripple-enabled, with digit k stepping only when all lower digits are at the wrap value.

Verification
REQ-031 SHALL cover: DIGITS=2, load 8'h03, up=0, en=1, auto_reload=0 -> count 02,01,00, then done pulse, halted=1, count holds 00.
REQ-032 SHALL cover: load 8'h10, down -> 10->09 (borrow across digits), no non-BCD value ever observed.
REQ-033 SHALL cover: load 8'h98, up=1, auto_reload=1 -> 99, tc=1 on 99, then 00 with one-cycle done.
REQ-034 SHALL cover: load 8'h2A -> count reads 29 (digit clamp); loadn=0 with en=0 still loads.
REQ-035 SHALL cover: clr pulsed mid-count at 05 -> count=00 immediately (async), no done, and en ignored until the next load.
REQ-036 SHALL cover: loadn=0 coinciding with the terminal step -> count=data, no done, state RUN.
